// File: rtl/cpu7_ibuf.sv
// cpu7_ibuf: circular instruction buffer between fetch and decode/issue.
//
// Up to FETCH_W instructions enter per fetch group. Up to ISSUE_W
// instructions leave per cycle, oldest first, from lane 0 upward.
//
// Ports
//   clk, reset     clock; synchronous active-high reset
//   fetch_*        fetch group: valid, slot-0 pc, slot count, packed slots,
//                  exception flag and exception code
//   fetch_ready    room for a full group (registered count only)
//   flush          branch redirect; empties the buffer at the next edge
//   issue_*        per-lane valid, instruction, pc, exception flag and code
//   issue_accept   number of lanes consumed this cycle, from lane 0 upward
//   occupancy      current entry count
//
// Handshake: a group transfers at a clock edge when
// fetch_valid & fetch_ready & (fetch_num != 0) & ~flush. While fetch_ready
// is low the group is ignored, and the producer holds it and retries.
// On the issue side, issue_accept may exceed the number of valid lanes;
// the excess is clipped.
module cpu7_ibuf #(
  parameter int DEPTH   = 8,
  parameter int FETCH_W = 4,
  parameter int ISSUE_W = 2,
  parameter int GRLEN   = 32,
  localparam int FW = $clog2(FETCH_W) + 1,
  localparam int IW = $clog2(ISSUE_W) + 1,
  localparam int OW = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fetch_valid,
  input  logic [GRLEN-1:0]         fetch_pc,
  input  logic [FW-1:0]            fetch_num,
  input  logic [32*FETCH_W-1:0]    fetch_rdata,
  input  logic                     fetch_ex,
  input  logic [5:0]               fetch_exccode,
  output logic                     fetch_ready,
  input  logic                     flush,
  output logic [ISSUE_W-1:0]       issue_valid,
  output logic [32*ISSUE_W-1:0]    issue_inst,
  output logic [GRLEN*ISSUE_W-1:0] issue_pc,
  output logic [ISSUE_W-1:0]       issue_ex,
  output logic [6*ISSUE_W-1:0]     issue_exccode,
  input  logic [IW-1:0]            issue_accept,
  output logic [OW-1:0]            occupancy
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [OW-1:0]    count;

  // Payload storage is deliberately not reset; validity comes from count.
  logic [31:0]      mem_inst [DEPTH];
  logic [GRLEN-1:0] mem_pc   [DEPTH];
  logic             mem_ex   [DEPTH];
  logic [5:0]       mem_code [DEPTH];

  logic [FW-1:0]    n_push;
  logic             push;
  logic [IW-1:0]    n_valid;
  logic [IW-1:0]    pop;

  // No credit for same-cycle pops: keeps fetch_ready off the issue path.
  assign fetch_ready = (int'(count) + FETCH_W <= DEPTH);
  assign occupancy   = count;

  // An exception group always occupies exactly one entry.
  always_comb begin
    n_push = '0;
    if (fetch_ex) begin
      n_push = FW'(1);
    end else if (int'(fetch_num) > FETCH_W) begin
      n_push = FW'(FETCH_W);
    end else begin
      n_push = fetch_num;
    end
  end

  assign push = fetch_valid & fetch_ready & (fetch_num != '0) & ~flush;

  // Lanes read straight from storage. An exception entry blocks every lane
  // behind it, so it can only issue as the last valid lane.
  always_comb begin
    logic [PW-1:0] idx;
    logic          blocked;
    idx           = '0;
    blocked       = 1'b0;
    n_valid       = '0;
    issue_valid   = '0;
    issue_inst    = '0;
    issue_pc      = '0;
    issue_ex      = '0;
    issue_exccode = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      idx                        = rd_ptr + PW'(i);
      issue_inst[32*i +: 32]     = mem_inst[idx];
      issue_pc[GRLEN*i +: GRLEN] = mem_pc[idx];
      issue_ex[i]                = mem_ex[idx];
      issue_exccode[6*i +: 6]    = mem_code[idx];
      if ((int'(count) > i) && !blocked) begin
        issue_valid[i] = 1'b1;
        n_valid        = n_valid + IW'(1);
        blocked        = mem_ex[idx];
      end
    end
  end

  assign pop = (issue_accept > n_valid) ? n_valid : issue_accept;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PW'(pop);
      if (push) begin
        wr_ptr <= wr_ptr + PW'(n_push);
      end
      count <= count + (push ? OW'(n_push) : OW'(0)) - OW'(pop);
    end
  end

  // PCs advance by 4 per slot and wrap at GRLEN bits.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      for (int i = 0; i < FETCH_W; i++) begin
        if (i < int'(n_push)) begin
          if (fetch_ex) begin
            mem_inst[wr_ptr + PW'(i)] <= '0;
            mem_pc[wr_ptr + PW'(i)]   <= fetch_pc;
            mem_ex[wr_ptr + PW'(i)]   <= 1'b1;
            mem_code[wr_ptr + PW'(i)] <= fetch_exccode;
          end else begin
            mem_inst[wr_ptr + PW'(i)] <= fetch_rdata[32*i +: 32];
            mem_pc[wr_ptr + PW'(i)]   <= fetch_pc + GRLEN'(4 * i);
            mem_ex[wr_ptr + PW'(i)]   <= 1'b0;
            mem_code[wr_ptr + PW'(i)] <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cpu7_ibuf.sv
// Bench for cpu7_ibuf at DEPTH=8, FETCH_W=4, ISSUE_W=2, GRLEN=32.
// Each table row gives one cycle of inputs and the occupancy, fetch_ready
// and issue_valid expected after the edge. Entry payloads are tracked in a
// scoreboard queue and compared on every lane the table marks valid.
module tb_cpu7_ibuf;

  localparam int W = 71;  // {ex, exccode, pc, inst}

  logic         clk;
  logic         reset;
  logic         fetch_valid;
  logic [31:0]  fetch_pc;
  logic [2:0]   fetch_num;
  logic [127:0] fetch_rdata;
  logic         fetch_ex;
  logic [5:0]   fetch_exccode;
  logic         fetch_ready;
  logic         flush;
  logic [1:0]   issue_valid;
  logic [63:0]  issue_inst;
  logic [63:0]  issue_pc;
  logic [1:0]   issue_ex;
  logic [11:0]  issue_exccode;
  logic [1:0]   issue_accept;
  logic [3:0]   occupancy;

  cpu7_ibuf #(.DEPTH(8), .FETCH_W(4), .ISSUE_W(2), .GRLEN(32)) dut (
    .clk(clk), .reset(reset),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_num(fetch_num),
    .fetch_rdata(fetch_rdata), .fetch_ex(fetch_ex), .fetch_exccode(fetch_exccode),
    .fetch_ready(fetch_ready), .flush(flush),
    .issue_valid(issue_valid), .issue_inst(issue_inst), .issue_pc(issue_pc),
    .issue_ex(issue_ex), .issue_exccode(issue_exccode),
    .issue_accept(issue_accept), .occupancy(occupancy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        fv;
    logic [31:0] pc;
    logic [2:0]  num;
    logic        ex;
    logic [5:0]  code;
    logic        fl;
    logic [1:0]  acc;
    logic [3:0]  occ;
    logic        rdy;
    logic [1:0]  vld;
  } vec_t;

  vec_t         vecs[29];
  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           errors = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    fetch_valid   = 1'b0;
    fetch_pc      = '0;
    fetch_num     = '0;
    fetch_rdata   = '0;
    fetch_ex      = 1'b0;
    fetch_exccode = '0;
    flush         = 1'b0;
    issue_accept  = '0;
  endtask

  function automatic int model_valid();
    if (exp_q.size() == 0) return 0;
    if (exp_q.size() == 1 || exp_q[0][70]) return 1;
    return 2;
  endfunction

  // driver: apply one row, advance one edge, compare against table and scoreboard
  task automatic apply(input int row, input vec_t v);
    logic [31:0] slot[4];
    int          npop;
    logic [W-1:0] act;
    for (int i = 0; i < 4; i++) slot[i] = $urandom;
    fetch_valid   = v.fv;
    fetch_pc      = v.pc;
    fetch_num     = v.num;
    fetch_ex      = v.ex;
    fetch_exccode = v.code;
    flush         = v.fl;
    issue_accept  = v.acc;
    for (int i = 0; i < 4; i++) fetch_rdata[32*i +: 32] = slot[i];

    if (v.fl) begin
      exp_q.delete();
    end else begin
      logic rdy_m;
      rdy_m = (exp_q.size() <= 4);
      npop  = (int'(v.acc) < model_valid()) ? int'(v.acc) : model_valid();
      repeat (npop) void'(exp_q.pop_front());
      if (v.fv && rdy_m && v.num != 0) begin
        if (v.ex) exp_q.push_back({1'b1, v.code, v.pc, 32'h0});
        else for (int i = 0; i < int'(v.num); i++)
          exp_q.push_back({1'b0, 6'h0, v.pc + 32'(4 * i), slot[i]});
      end
    end

    @(posedge clk);
    #1;
    check($sformatf("row%0d occupancy", row), W'(occupancy), W'(v.occ));
    check($sformatf("row%0d fetch_ready", row), W'(fetch_ready), W'(v.rdy));
    check($sformatf("row%0d issue_valid", row), W'(issue_valid), W'(v.vld));
    for (int i = 0; i < 2; i++) begin
      if (v.vld[i]) begin
        act = {issue_ex[i], issue_ex[i] ? issue_exccode[6*i +: 6] : 6'h0,
               issue_pc[32*i +: 32], issue_inst[32*i +: 32]};
        if (exp_q.size() > i) check($sformatf("row%0d lane%0d payload", row, i), act, exp_q[i]);
        else check($sformatf("row%0d lane%0d scoreboard empty", row, i), act, {W{1'bx}});
      end
    end
  endtask

  initial begin
    //            fv  pc            num ex code   fl acc occ rdy vld
    vecs[0]  = '{1, 32'h1c000000, 4, 0, 6'h00, 0, 0, 4, 1, 2'b11}; // basic push
    vecs[1]  = '{1, 32'h1c000010, 4, 0, 6'h00, 0, 0, 8, 0, 2'b11}; // full
    vecs[2]  = '{1, 32'h1c000020, 4, 0, 6'h00, 0, 0, 8, 0, 2'b11}; // ignored when full
    vecs[3]  = '{0, 32'h0,        0, 0, 6'h00, 0, 2, 6, 0, 2'b11};
    vecs[4]  = '{0, 32'h0,        0, 0, 6'h00, 0, 2, 4, 1, 2'b11};
    vecs[5]  = '{0, 32'h0,        0, 0, 6'h00, 0, 1, 3, 1, 2'b11};
    vecs[6]  = '{1, 32'h1c000040, 4, 0, 6'h00, 0, 0, 7, 0, 2'b11}; // writes idx 0..3 after 7
    vecs[7]  = '{0, 32'h0,        0, 0, 6'h00, 0, 2, 5, 0, 2'b11}; // lanes straddle the wrap
    vecs[8]  = '{1, 32'h1c000050, 4, 0, 6'h00, 0, 2, 3, 1, 2'b11}; // pop not credited
    vecs[9]  = '{1, 32'h1c000050, 4, 0, 6'h00, 0, 2, 5, 0, 2'b11}; // push + pop together
    vecs[10] = '{1, 32'h1c000060, 1, 0, 6'h00, 0, 2, 3, 1, 2'b11};
    vecs[11] = '{0, 32'h0,        0, 0, 6'h00, 0, 2, 1, 1, 2'b01};
    vecs[12] = '{0, 32'h0,        0, 0, 6'h00, 0, 2, 0, 1, 2'b00}; // accept clipped
    vecs[13] = '{0, 32'h0,        0, 0, 6'h00, 0, 2, 0, 1, 2'b00}; // no underflow
    vecs[14] = '{1, 32'hfffffffc, 2, 0, 6'h00, 0, 0, 2, 1, 2'b11}; // pc wrap
    vecs[15] = '{0, 32'h0,        0, 0, 6'h00, 0, 2, 0, 1, 2'b00};
    vecs[16] = '{1, 32'h1c000010, 4, 1, 6'h08, 0, 0, 1, 1, 2'b01}; // exception entry
    vecs[17] = '{1, 32'h1c000020, 4, 0, 6'h00, 0, 0, 5, 0, 2'b01}; // masked behind ex
    vecs[18] = '{0, 32'h0,        0, 0, 6'h00, 0, 2, 4, 1, 2'b11}; // only ex pops
    vecs[19] = '{1, 32'h1c000030, 1, 0, 6'h00, 0, 0, 5, 0, 2'b11};
    vecs[20] = '{1, 32'h1c000040, 4, 0, 6'h00, 1, 2, 0, 1, 2'b00}; // flush priority
    vecs[21] = '{1, 32'h1c000070, 3, 0, 6'h00, 0, 0, 3, 1, 2'b11}; // accepted after flush
    vecs[22] = '{1, 32'h1c000080, 4, 0, 6'h00, 1, 1, 0, 1, 2'b00}; // flush drops a ready push
    vecs[23] = '{1, 32'h1c000090, 0, 0, 6'h00, 0, 0, 0, 1, 2'b00}; // num=0 is no push
    vecs[24] = '{1, 32'h1c0000a0, 4, 0, 6'h00, 0, 0, 4, 1, 2'b11};
    vecs[25] = '{1, 32'h1c0000b0, 2, 1, 6'h0a, 0, 0, 5, 0, 2'b11};
    vecs[26] = '{0, 32'h0,        0, 0, 6'h00, 0, 2, 3, 1, 2'b11};
    vecs[27] = '{0, 32'h0,        0, 0, 6'h00, 0, 2, 1, 1, 2'b01}; // ex alone in lane 0
    vecs[28] = '{0, 32'h0,        0, 0, 6'h00, 0, 1, 0, 1, 2'b00};

    // reset state
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset occupancy", W'(occupancy), W'(0));
    check("reset fetch_ready", W'(fetch_ready), W'(1));
    check("reset issue_valid", W'(issue_valid), W'(0));
    @(posedge clk);
    #1;
    check("post-reset occupancy", W'(occupancy), W'(0));

    for (int r = 0; r < 29; r++) apply(r, vecs[r]);

    // mid-operation reset discards entries and a concurrent push
    apply(100, '{1, 32'h1c000100, 4, 0, 6'h00, 0, 0, 4, 1, 2'b11});
    fetch_valid = 1'b1;
    fetch_num   = 3'd4;
    issue_accept = 2'd1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle_inputs();
    exp_q.delete();
    check("midreset occupancy", W'(occupancy), W'(0));
    check("midreset fetch_ready", W'(fetch_ready), W'(1));
    check("midreset issue_valid", W'(issue_valid), W'(0));

    // normal operation resumes
    apply(101, '{1, 32'h1c000200, 2, 0, 6'h00, 0, 0, 2, 1, 2'b11});
    apply(102, '{0, 32'h0,        0, 0, 6'h00, 0, 1, 1, 1, 2'b01});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
